exec_cond_stage: RTL and testbench
==================================

# exec_cond_stage

Execute-stage back end of the 32-bit ARM-like CPU. It sits directly downstream of the ALU and consumes `ALUResult` and the `{N,Z,C,V}` flag vector. It holds the architectural NZCV flag register and evaluates the instruction's 4-bit condition field against it. It then gates the register, memory and PC write enables and registers the result into a one-entry valid/ready pipeline slot that feeds memory/writeback.

## Interface
Parameters:
- `WIDTH`, 32, datapath width of result and store data.
- `RA_W`, 4, destination register index width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  upstream instruction valid.
- `in_ready`  out  1  stage can accept this cycle.
- `alu_result`  in  WIDTH  ALU result.
- `alu_flag`  in  4  `{N,Z,C,V}` from ALU.
- `cond`  in  4  ARM condition field.
- `flag_w`  in  2  bit1 updates N,Z; bit0 updates C,V.
- `reg_w`, `mem_w`, `pc_s`  in  1 each  unconditioned write/branch enables.
- `rd`  in  RA_W  destination register.
- `wdata`  in  WIDTH  store data.
- `flush`  in  1  discard held entry (branch redirect).
- `out_valid`  out  1  slot holds an instruction.
- `out_ready`  in  1  downstream accepts.
- `out_result`, `out_wdata`  out  WIDTH  registered result and store data.
- `out_rd`  out  RA_W  registered destination.
- `out_reg_w`, `out_mem_w`, `out_pc_s`  out  1 each  enables ANDed with condition pass.
- `out_cond_ex`  out  1  condition passed for held instruction.
- `flags`  out  4  architectural `{N,Z,C,V}`.
- `exec_cnt`, `skip_cnt`  out  16 each  accepted instructions whose condition passed or failed.

## Operation
- Accept = `in_valid & in_ready & ~flush`. `in_ready` = `~flush & (~out_valid | out_ready)`.
- Condition pass is combinational from the current `flags` register, not from `alu_flag`:
  - EQ 0000: Z. NE 0001: ~Z.
  - CS 0010: C. CC 0011: ~C.
  - MI 0100: N. PL 0101: ~N.
  - VS 0110: V. VC 0111: ~V.
  - HI 1000: C&~Z. LS 1001: ~C|Z.
  - GE 1010: N==V. LT 1011: N!=V.
  - GT 1100: ~Z&(N==V). LE 1101: Z|(N!=V).
  - AL 1110: 1. 1111: treated as 1.
- On accept:
  - Slot loads `alu_result`, `wdata`, `rd`, `cond_ex`, and `reg_w/mem_w/pc_s & cond_ex`.
  - `out_valid` is set to 1.
  - If `cond_ex & flag_w[1]`, flags N,Z take `alu_flag[3:2]`.
  - If `cond_ex & flag_w[0]`, flags C,V take `alu_flag[1:0]`.
  - If `cond_ex`, `exec_cnt` increments by 1; otherwise `skip_cnt` increments by 1. Both wrap 0xFFFF to 0x0000.
- Failed-condition instructions still occupy the slot and are handed downstream with all enables 0. This keeps PC/retire accounting uniform.
- No accept while `out_valid & ~out_ready`: the slot contents are held stable.
- With `out_valid & out_ready & ~in_valid`, `out_valid` clears next edge.
- Flush: next edge `out_valid`=0. No accept, no flag update, no counter update that cycle. Flush beats both `out_ready` and `in_valid`.
- Slot states are EMPTY (`out_valid`=0) and FULL (`out_valid`=1):
  - EMPTY→FULL on accept.
  - FULL→FULL on accept, or when held because `~out_ready`.
  - FULL→EMPTY on `out_ready` with no accept, or on flush.
  - EMPTY→EMPTY on flush.

## Timing
- Reset (`rst_n`=0, immediate, asynchronous): `out_valid`=0, `flags`=4'b0000, and all `out_*` data/enables=0. Both counters=0.
- Latency: one cycle, accept edge to `out_*` valid.
- Flag update is visible to the condition of the next accepted instruction the following cycle. Back-to-back dependent conditionals therefore need no forwarding and no bubble.
- Throughput: one instruction per cycle while `out_ready`=1.
- `in_ready` depends combinationally on `out_ready` and `flush`. No other comb path input→output exists.
- `rst_n` deassertion is synchronised externally; the block sees a clean edge.
- Reset asserted mid-transfer drops the held entry and restores the reset values above. No partial flag update survives.

## Test plan
- Reset: drive `rst_n`=0 with `in_valid`=1 → `out_valid`=0, `flags`=0000, counters 0. After release, first accept gives `out_valid`=1 next cycle.
- Flag set then EQ: accept SUB 5-5 (`alu_flag`=0110, `flag_w`=11, AL) → `flags`=0110. Next cycle accept `cond`=0000, `reg_w`=1 → `out_reg_w`=1, `out_cond_ex`=1, `exec_cnt`=2.
- Failed condition gates writes and flags: with `flags`=0110, accept `cond`=0001, `reg_w`=`mem_w`=1, `flag_w`=11, `alu_flag`=1000 → enables 0, `flags` stays 0110, `skip_cnt`=1.
- Backpressure: `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0, outputs stable, flags/counters frozen. `out_ready`=1 → one accept per cycle resumes.
- Flush priority: `out_valid`=1, `flush`=1, `in_valid`=1, `out_ready`=1 → next cycle `out_valid`=0, flags and counters unchanged.
- Signed conditions and counter wrap:
  - `flags`=1001 → GE and GT pass, LT fails.
  - Preload `exec_cnt` to 0xFFFF via 65535 accepts, then one more → 0x0000.

Source files
------------

// File: rtl/exec_cond_stage_if.sv
// Bundles the execute back-end signals: the ALU-side issue channel plus the
// registered valid/ready slot toward memory/writeback.
interface exec_cond_stage_if #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flag;
  logic [3:0]       cond;
  logic [1:0]       flag_w;
  logic             reg_w;
  logic             mem_w;
  logic             pc_s;
  logic [RA_W-1:0]  rd;
  logic [WIDTH-1:0] wdata;
  logic             flush;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [WIDTH-1:0] out_wdata;
  logic [RA_W-1:0]  out_rd;
  logic             out_reg_w;
  logic             out_mem_w;
  logic             out_pc_s;
  logic             out_cond_ex;
  logic [3:0]       flags;
  logic [15:0]      exec_cnt;
  logic [15:0]      skip_cnt;

  modport master (
    output in_valid, alu_result, alu_flag, cond, flag_w, reg_w, mem_w, pc_s,
           rd, wdata, flush, out_ready,
    input  in_ready, out_valid, out_result, out_wdata, out_rd, out_reg_w,
           out_mem_w, out_pc_s, out_cond_ex, flags, exec_cnt, skip_cnt
  );

  modport slave (
    input  in_valid, alu_result, alu_flag, cond, flag_w, reg_w, mem_w, pc_s,
           rd, wdata, flush, out_ready,
    output in_ready, out_valid, out_result, out_wdata, out_rd, out_reg_w,
           out_mem_w, out_pc_s, out_cond_ex, flags, exec_cnt, skip_cnt
  );
endinterface

// File: rtl/exec_cond_stage.sv
// Execute-stage back end: owns the NZCV register, evaluates the ARM condition
// field, gates write enables and registers the result into a one-entry slot.
module exec_cond_stage #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 4
) (
  input logic               clk,
  input logic               rst_n,
  exec_cond_stage_if.slave  bus
);
  typedef enum logic {S_EMPTY, S_FULL} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [RA_W-1:0]  rd_q, rd_d;
  logic             reg_w_q, reg_w_d;
  logic             mem_w_q, mem_w_d;
  logic             pc_s_q, pc_s_d;
  logic             cond_ex_q, cond_ex_d;
  logic [3:0]       flags_q, flags_d;
  logic [15:0]      exec_cnt_q, exec_cnt_d;
  logic [15:0]      skip_cnt_q, skip_cnt_d;

  logic cond_pass;
  logic in_ready;
  logic accept;
  logic n_f, z_f, c_f, v_f;

  assign {n_f, z_f, c_f, v_f} = flags_q;

  // Condition is judged against the architectural register, never alu_flag,
  // so a flag-setting op affects only the instructions that follow it.
  always_comb begin
    cond_pass = 1'b1;
    unique case (bus.cond)
      4'b0000: cond_pass = z_f;
      4'b0001: cond_pass = ~z_f;
      4'b0010: cond_pass = c_f;
      4'b0011: cond_pass = ~c_f;
      4'b0100: cond_pass = n_f;
      4'b0101: cond_pass = ~n_f;
      4'b0110: cond_pass = v_f;
      4'b0111: cond_pass = ~v_f;
      4'b1000: cond_pass = c_f & ~z_f;
      4'b1001: cond_pass = ~c_f | z_f;
      4'b1010: cond_pass = (n_f == v_f);
      4'b1011: cond_pass = (n_f != v_f);
      4'b1100: cond_pass = ~z_f & (n_f == v_f);
      4'b1101: cond_pass = z_f | (n_f != v_f);
      default: cond_pass = 1'b1;
    endcase
  end

  assign in_ready = ~bus.flush & ((state_q == S_EMPTY) | bus.out_ready);
  assign accept   = bus.in_valid & in_ready;

  // NOTE: every always_comb target gets a hold/default value first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    reg_w_d    = reg_w_q;
    mem_w_d    = mem_w_q;
    pc_s_d     = pc_s_q;
    cond_ex_d  = cond_ex_q;
    flags_d    = flags_q;
    exec_cnt_d = exec_cnt_q;
    skip_cnt_d = skip_cnt_q;

    if (bus.flush) begin
      state_d = S_EMPTY;
    end else if (accept) begin
      state_d   = S_FULL;
      result_d  = bus.alu_result;
      wdata_d   = bus.wdata;
      rd_d      = bus.rd;
      cond_ex_d = cond_pass;
      reg_w_d   = bus.reg_w & cond_pass;
      mem_w_d   = bus.mem_w & cond_pass;
      pc_s_d    = bus.pc_s & cond_pass;
      if (cond_pass) begin
        exec_cnt_d = exec_cnt_q + 16'd1;
        if (bus.flag_w[1]) flags_d[3:2] = bus.alu_flag[3:2];
        if (bus.flag_w[0]) flags_d[1:0] = bus.alu_flag[1:0];
      end else begin
        skip_cnt_d = skip_cnt_q + 16'd1;
      end
    end else if (state_q == S_FULL && bus.out_ready) begin
      state_d = S_EMPTY;
    end
  end

  // NOTE: the slot payload is reset along with the control state because
  // downstream observes out_* as all-zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      result_q   <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      reg_w_q    <= 1'b0;
      mem_w_q    <= 1'b0;
      pc_s_q     <= 1'b0;
      cond_ex_q  <= 1'b0;
      flags_q    <= 4'b0000;
      exec_cnt_q <= 16'd0;
      skip_cnt_q <= 16'd0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      state_q    <= state_d;
      result_q   <= result_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      reg_w_q    <= reg_w_d;
      mem_w_q    <= mem_w_d;
      pc_s_q     <= pc_s_d;
      cond_ex_q  <= cond_ex_d;
      flags_q    <= flags_d;
      exec_cnt_q <= exec_cnt_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = (state_q == S_FULL);
  assign bus.out_result  = result_q;
  assign bus.out_wdata   = wdata_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_reg_w   = reg_w_q;
  assign bus.out_mem_w   = mem_w_q;
  assign bus.out_pc_s    = pc_s_q;
  assign bus.out_cond_ex = cond_ex_q;
  assign bus.flags       = flags_q;
  assign bus.exec_cnt    = exec_cnt_q;
  assign bus.skip_cnt    = skip_cnt_q;
endmodule

// File: tb/tb_exec_cond_stage.sv
// Directed bench for exec_cond_stage: reset, flag/condition behaviour,
// backpressure, flush priority, signed conditions and counter wrap.
module tb_exec_cond_stage;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  exec_cond_stage_if #(.WIDTH(32), .RA_W(4)) bus ();

  exec_cond_stage #(.WIDTH(32), .RA_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] af,
                       input logic [31:0] res, input logic rw, input logic mw, input logic ps);
    bus.in_valid   = 1'b1;
    bus.cond       = c;
    bus.flag_w     = fw;
    bus.alu_flag   = af;
    bus.alu_result = res;
    bus.wdata      = ~res;
    bus.reg_w      = rw;
    bus.mem_w      = mw;
    bus.pc_s       = ps;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n          = 1'b0;
    bus.in_valid   = 1'b1;
    bus.alu_result = 32'hDEAD_BEEF;
    bus.alu_flag   = 4'b1111;
    bus.cond       = 4'b1110;
    bus.flag_w     = 2'b11;
    bus.reg_w      = 1'b1;
    bus.mem_w      = 1'b1;
    bus.pc_s       = 1'b1;
    bus.rd         = 4'd7;
    bus.wdata      = 32'h1;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b1;

    // Reset held with in_valid high
    tick(); tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_flags",     32'(bus.flags),     32'd0);
    check("rst_exec_cnt",  32'(bus.exec_cnt),  32'd0);
    check("rst_skip_cnt",  32'(bus.skip_cnt),  32'd0);
    check("rst_out_result", bus.out_result,    32'd0);
    check("rst_out_reg_w", 32'(bus.out_reg_w), 32'd0);

    // SUB 5-5 under AL sets Z and C
    rst_n = 1'b1;
    bus.rd = 4'd3;
    drive(4'b1110, 2'b11, 4'b0110, 32'd0, 1'b1, 1'b0, 1'b0);
    tick();
    check("first_out_valid", 32'(bus.out_valid), 32'd1);
    check("sub_flags",       32'(bus.flags),     32'h6);
    check("sub_exec_cnt",    32'(bus.exec_cnt),  32'd1);
    check("sub_out_rd",      32'(bus.out_rd),    32'd3);

    // EQ passes on the freshly written Z
    drive(4'b0000, 2'b00, 4'b0000, 32'h1234, 1'b1, 1'b0, 1'b0);
    tick();
    check("eq_out_reg_w",   32'(bus.out_reg_w),   32'd1);
    check("eq_out_cond_ex", 32'(bus.out_cond_ex), 32'd1);
    check("eq_exec_cnt",    32'(bus.exec_cnt),    32'd2);
    check("eq_out_result",  bus.out_result,       32'h1234);
    check("eq_out_wdata",   bus.out_wdata,        ~32'h1234);

    // NE fails: enables and flags gated
    drive(4'b0001, 2'b11, 4'b1000, 32'h5555, 1'b1, 1'b1, 1'b0);
    tick();
    check("ne_out_reg_w",   32'(bus.out_reg_w),   32'd0);
    check("ne_out_mem_w",   32'(bus.out_mem_w),   32'd0);
    check("ne_out_cond_ex", 32'(bus.out_cond_ex), 32'd0);
    check("ne_flags",       32'(bus.flags),       32'h6);
    check("ne_skip_cnt",    32'(bus.skip_cnt),    32'd1);
    check("ne_out_valid",   32'(bus.out_valid),   32'd1);

    // Backpressure for three cycles
    bus.out_ready = 1'b0;
    drive(4'b1110, 2'b11, 4'b1001, 32'hAAAA, 1'b1, 1'b0, 1'b0);
    #1;
    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    tick(); tick(); tick();
    check("bp_out_result", bus.out_result,     32'h5555);
    check("bp_out_valid",  32'(bus.out_valid), 32'd1);
    check("bp_flags",      32'(bus.flags),     32'h6);
    check("bp_exec_cnt",   32'(bus.exec_cnt),  32'd2);
    check("bp_skip_cnt",   32'(bus.skip_cnt),  32'd1);

    bus.out_ready = 1'b1;
    #1;
    check("resume_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("resume_out_result", bus.out_result,    32'hAAAA);
    check("resume_flags",      32'(bus.flags),    32'h9);
    check("resume_exec_cnt",   32'(bus.exec_cnt), 32'd3);

    // flags = 1001: N=1 Z=0 C=0 V=1
    drive(4'b1010, 2'b00, 4'b0000, 32'h1, 1'b1, 1'b0, 1'b0);
    tick();
    check("ge_cond_ex", 32'(bus.out_cond_ex), 32'd1);
    check("ge_exec_cnt", 32'(bus.exec_cnt),   32'd4);
    drive(4'b1100, 2'b00, 4'b0000, 32'h2, 1'b1, 1'b0, 1'b0);
    tick();
    check("gt_cond_ex", 32'(bus.out_cond_ex), 32'd1);
    drive(4'b1011, 2'b00, 4'b0000, 32'h3, 1'b1, 1'b0, 1'b0);
    tick();
    check("lt_cond_ex",  32'(bus.out_cond_ex), 32'd0);
    check("lt_skip_cnt", 32'(bus.skip_cnt),    32'd2);
    drive(4'b1000, 2'b00, 4'b0000, 32'h4, 1'b0, 1'b0, 1'b1);
    tick();
    check("hi_out_pc_s", 32'(bus.out_pc_s), 32'd0);
    check("hi_skip_cnt", 32'(bus.skip_cnt), 32'd3);
    drive(4'b1001, 2'b00, 4'b0000, 32'h5, 1'b0, 1'b0, 1'b1);
    tick();
    check("ls_out_pc_s", 32'(bus.out_pc_s), 32'd1);
    check("ls_exec_cnt", 32'(bus.exec_cnt), 32'd6);

    // Flush beats in_valid and out_ready
    drive(4'b1110, 2'b11, 4'b0000, 32'h6, 1'b1, 1'b0, 1'b0);
    bus.flush = 1'b1;
    #1;
    check("flush_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    bus.flush = 1'b0;
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_flags",     32'(bus.flags),     32'h9);
    check("flush_exec_cnt",  32'(bus.exec_cnt),  32'd6);
    check("flush_skip_cnt",  32'(bus.skip_cnt),  32'd3);

    // Accept then drain
    drive(4'b1110, 2'b00, 4'b0000, 32'h7, 1'b0, 1'b0, 1'b0);
    tick();
    check("refill_out_valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b0;
    tick();
    check("drain_out_valid", 32'(bus.out_valid), 32'd0);
    check("drain_exec_cnt",  32'(bus.exec_cnt),  32'd7);

    // exec_cnt wrap
    drive(4'b1110, 2'b00, 4'b0000, 32'h8, 1'b0, 1'b0, 1'b0);
    for (int i = 7; i < 65535; i++) tick();
    check("wrap_pre",  32'(bus.exec_cnt), 32'hFFFF);
    tick();
    check("wrap_post", 32'(bus.exec_cnt), 32'h0000);
    check("wrap_skip", 32'(bus.skip_cnt), 32'd3);

    // Asynchronous reset mid-cycle while full
    drive(4'b1110, 2'b11, 4'b1111, 32'h9, 1'b1, 1'b1, 1'b1);
    tick();
    check("pre_arst_flags", 32'(bus.flags), 32'hF);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_flags",     32'(bus.flags),     32'd0);
    check("arst_exec_cnt",  32'(bus.exec_cnt),  32'd0);
    check("arst_out_reg_w", 32'(bus.out_reg_w), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
